// File: rtl/coax_tx.sv
// Manchester-coded coax frame transmitter: quiesce, violation, then sync/data/parity per word, then an end sequence.
// Optional pre-emphasis output and drain tail are enabled by defining COAX_TX_PREEMPHASIS_EN.
module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       tx_delay,
  output logic       active
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_VIOL, S_SYNC, S_DATA, S_PARITY, S_END
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cell_q, cell_d;
  logic [9:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic [9:0]    shift_q, shift_d;
  logic          par_q, par_d;

  logic accept;
  logic load;
  logic cell_end;
  logic first_half;
  logic done;

  assign accept     = valid && !full_q;
  assign cell_end   = (cnt_q == CW'(CLOCKS_PER_BIT - 1));
  assign first_half = (cnt_q < CW'(HALF));
  assign load       = (state_q == S_SYNC) && (cnt_q == '0) && (cell_q == 4'd0);
  assign ready      = !full_q;
  assign active     = (state_q != S_IDLE);

  // Last clock of the current state.
  always_comb begin
    done = 1'b0;
    case (state_q)
      S_QUIESCE: done = cell_end && (cell_q == 4'd4);
      S_VIOL:    done = cell_end && (cell_q == 4'd2);
      S_SYNC:    done = cell_end;
      S_DATA:    done = cell_end && (cell_q == 4'd9);
      S_PARITY:  done = cell_end;
`ifdef COAX_TX_PREEMPHASIS_EN
      S_END:     done = (cell_q == 4'd3) && (cnt_q == CW'(HALF - 1));
`else
      S_END:     done = cell_end && (cell_q == 4'd2);
`endif
      default:   done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (full_q) state_d = S_QUIESCE;
      S_QUIESCE: if (done) state_d = S_VIOL;
      S_VIOL:    if (done) state_d = S_SYNC;
      S_SYNC:    if (done) state_d = S_DATA;
      S_DATA:    if (done) state_d = S_PARITY;
      // A word landing on the final parity clock still chains into this frame.
      S_PARITY:  if (done) state_d = (full_q || accept) ? S_SYNC : S_END;
      S_END:     if (done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    hold_d  = hold_q;
    full_d  = full_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q == S_IDLE || done) begin
      cnt_d  = '0;
      cell_d = 4'd0;
    end else if (cell_end) begin
      cnt_d  = '0;
      cell_d = cell_q + 4'd1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
    if (accept) begin
      hold_d = data;
      full_d = 1'b1;
    end else if (load) begin
      full_d = 1'b0;
    end
    if (load) begin
      shift_d = hold_q;
      par_d   = ^hold_q;
    end else if (state_q == S_DATA && cell_end) begin
      shift_d = {shift_q[8:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      cell_q  <= 4'd0;
      hold_q  <= 10'd0;
      full_q  <= 1'b0;
      shift_q <= 10'd0;
      par_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Manchester cell: ~b in the first half, b in the second.
  always_comb begin
    tx = 1'b0;
    case (state_q)
      S_QUIESCE: tx = !first_half;
      S_VIOL:    tx = (cell_q == 4'd0) || ((cell_q == 4'd1) && first_half);
      S_SYNC:    tx = !first_half;
      S_DATA:    tx = first_half ? !shift_q[9] : shift_q[9];
      S_PARITY:  tx = first_half ? !par_q : par_q;
      S_END:     tx = ((cell_q == 4'd0) && first_half) || (cell_q == 4'd1);
      default:   tx = 1'b0;
    endcase
  end

`ifdef COAX_TX_PREEMPHASIS_EN
  logic [HALF-1:0] dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                dly_q <= '0;
    else if (state_q == S_IDLE) dly_q <= '0;
    else                        dly_q <= {dly_q[HALF-2:0], tx};
  end

  assign tx_delay = dly_q[HALF-1];
`else
  assign tx_delay = 1'b0;
`endif

endmodule

// File: tb/tb_coax_tx.sv
// Scoreboard bench for coax_tx at CLOCKS_PER_BIT=4: expected line samples are queued per frame and popped while active.
module tb_coax_tx;

  localparam int CPB = 4;
  localparam int H   = CPB / 2;
`ifdef COAX_TX_PREEMPHASIS_EN
  localparam int EXTRA = H;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] data = 10'd0;
  logic       valid = 1'b0;
  logic       ready, tx, tx_delay, active;

  int checks = 0;
  int passed = 0;
  bit exp_q[$];

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .tx_delay(tx_delay), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_cell(bit b);
    for (int i = 0; i < CPB; i++) exp_q.push_back(i < H ? ~b : b);
  endfunction

  function automatic void push_start();
    for (int i = 0; i < 5; i++) push_cell(1'b1);
    for (int i = 0; i < 3 * H; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 3 * H; i++) exp_q.push_back(1'b0);
  endfunction

  function automatic void push_word(logic [9:0] w);
    push_cell(1'b1);
    for (int i = 9; i >= 0; i--) push_cell(w[i]);
    push_cell(^w);
  endfunction

  function automatic void push_end();
    push_cell(1'b0);
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < EXTRA; i++) exp_q.push_back(1'b0);
  endfunction

  // Waits (bounded) for active, then pops one expected sample per active clock.
  task automatic capture(output int len, output int errs, output int derrs);
    int w;
    bit hist[$];
    bit e;
    bit ed;
    w = 0; len = 0; errs = 0; derrs = 0;
    while (!active && w < 400) begin @(negedge clk); w++; end
    while (active && len < 2000) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (tx !== e) errs++;
      end else begin
        errs++;
      end
`ifdef COAX_TX_PREEMPHASIS_EN
      ed = (len >= H) ? hist[len-H] : 1'b0;
`else
      ed = 1'b0;
`endif
      if (tx_delay !== ed) derrs++;
      hist.push_back(tx);
      len++;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    int t;
    t = 0;
    while (!ready && t < 500) begin @(negedge clk); t++; end
    data = w;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset();
    int len, errs, derrs;
    reset = 1'b0; valid = 1'b1; data = 10'h155;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b0) $display("FAIL reset_tx: got %b want 0", tx); else passed++;
    checks++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    push_start(); push_word(10'h155); push_end();
    reset = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ready !== 1'b0) $display("FAIL reset_accept_ready: got %b want 0", ready); else passed++;
    capture(len, errs, derrs);
    checks++; if (len !== 92 + EXTRA) $display("FAIL reset_frame_len: got %0d want %0d", len, 92 + EXTRA); else passed++;
    checks++; if (errs !== 0) $display("FAIL reset_frame_wave: got %0d bad samples want 0", errs); else passed++;
    exp_q.delete();
  endtask

  task automatic test_single();
    int len, errs, derrs;
    push_start(); push_word(10'b1010000011); push_end();
    send_word(10'b1010000011);
    checks++; if (ready !== 1'b0) $display("FAIL single_ready: got %b want 0", ready); else passed++;
    capture(len, errs, derrs);
    checks++; if (len !== 92 + EXTRA) $display("FAIL single_len: got %0d want %0d", len, 92 + EXTRA); else passed++;
    checks++; if (errs !== 0) $display("FAIL single_wave: got %0d bad samples want 0", errs); else passed++;
    checks++; if (derrs !== 0) $display("FAIL single_tx_delay: got %0d bad samples want 0", derrs); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL single_leftover: got %0d want 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int len, errs, derrs, ign_bad, t;
    push_start(); push_word(10'h3FF); push_word(10'h001); push_end();
    send_word(10'h3FF);
    ign_bad = 0;
    fork
      capture(len, errs, derrs);
      begin
        t = 0;
        while (!active && t < 400) begin @(negedge clk); t++; end
        while (!ready && t < 800) begin @(negedge clk); t++; end
        repeat (8) @(negedge clk);
        data = 10'h001; valid = 1'b1;
        @(negedge clk);
        data = 10'h2AA;
        repeat (5) begin
          if (ready !== 1'b0) ign_bad++;
          @(negedge clk);
        end
        valid = 1'b0;
      end
    join
    checks++; if (ign_bad !== 0) $display("FAIL b2b_busy_ready: got %0d cycles ready want 0", ign_bad); else passed++;
    checks++; if (len !== 140 + EXTRA) $display("FAIL b2b_len: got %0d want %0d", len, 140 + EXTRA); else passed++;
    checks++; if (errs !== 0) $display("FAIL b2b_wave: got %0d bad samples want 0", errs); else passed++;
    checks++; if (derrs !== 0) $display("FAIL b2b_tx_delay: got %0d bad samples want 0", derrs); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_late_second();
    int len1, e1, d1, len2, e2, d2, t;
    logic gap_active, rdy80;
    push_start(); push_word(10'h0F0); push_end();
    push_start(); push_word(10'h30C); push_end();
    send_word(10'h0F0);
    gap_active = 1'b0; rdy80 = 1'b0;
    fork
      begin
        capture(len1, e1, d1);
        @(negedge clk);
        gap_active = active;
        capture(len2, e2, d2);
      end
      begin
        t = 0;
        while (!active && t < 400) begin @(negedge clk); t++; end
        repeat (80) @(negedge clk);
        rdy80 = ready;
        data = 10'h30C; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
      end
    join
    checks++; if (rdy80 !== 1'b1) $display("FAIL late_ready_in_end: got %b want 1", rdy80); else passed++;
    checks++; if (len1 !== 92 + EXTRA) $display("FAIL late_len1: got %0d want %0d", len1, 92 + EXTRA); else passed++;
    checks++; if (gap_active !== 1'b1) $display("FAIL late_idle_gap: got active %b want 1 after one idle cycle", gap_active); else passed++;
    checks++; if (len2 !== 92 + EXTRA) $display("FAIL late_len2: got %0d want %0d", len2, 92 + EXTRA); else passed++;
    checks++; if (e1 + e2 !== 0) $display("FAIL late_wave: got %0d bad samples want 0", e1 + e2); else passed++;
    checks++; if (d1 + d2 !== 0) $display("FAIL late_tx_delay: got %0d bad samples want 0", d1 + d2); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL late_leftover: got %0d want 0", exp_q.size()); else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int t, resid;
    logic seen;
    send_word(10'h2CF);
    t = 0;
    while (!active && t < 400) begin @(negedge clk); t++; end
    seen = active;
    while (!ready && t < 800) begin @(negedge clk); t++; end
    data = 10'h1E1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (seen !== 1'b1) $display("FAIL rmid_started: got %b want 1", seen); else passed++;
    #1 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b0) $display("FAIL rmid_tx: got %b want 0", tx); else passed++;
    checks++; if (active !== 1'b0) $display("FAIL rmid_active: got %b want 0", active); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", ready); else passed++;
    resid = 0;
    repeat (150) begin
      if (active !== 1'b0 || tx !== 1'b0 || tx_delay !== 1'b0) resid++;
      @(negedge clk);
    end
    checks++; if (resid !== 0) $display("FAIL rmid_residual: got %0d busy cycles want 0", resid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_late_second();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
